// File: rtl/c16_memctl_pkg.sv
// Shared types and constants for the C16 memory controller.
// Holds the FSM encoding, the access key layout, window constants and the RAM mask table.
package c16_mem_pkg;

   localparam int unsigned ADDR_W = 16;
   localparam int unsigned MEM_AW = 18;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned BANK_W = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      REQ    = 2'd2
   } state_t;

   // Everything that distinguishes one CPU bus access from the next
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic              rnw;
      logic              cs_ram;
      logic              cs0;
      logic              cs1;
   } acc_key_t;

   localparam logic [11:0]       BANK_REG_PAGE   = 12'hFDD;
   localparam logic [7:0]        KERNAL_PAGE     = 8'hFC;
   localparam logic [MEM_AW-1:0] ROM_LO_BASE_DEF = 18'h10000;
   localparam logic [MEM_AW-1:0] ROM_HI_BASE_DEF = 18'h20000;

   function automatic logic [ADDR_W-1:0] ram_mask(input logic [1:0] ram_size);
      case (ram_size)
         2'd0:    ram_mask = 16'h3FFF;
         2'd1:    ram_mask = 16'h7FFF;
         default: ram_mask = 16'hFFFF;
      endcase
   endfunction

endpackage

// File: rtl/c16_memctl_memmap.sv
// c16_memmap: combinational C16 bus -> external byte address / write-enable translation.
// CS priority is CS_RAM > CS0 > CS1; ROM windows never write.
module c16_memmap
   import c16_mem_pkg::*;
#(
   parameter logic [MEM_AW-1:0] ROM_LO_BASE = ROM_LO_BASE_DEF,
   parameter logic [MEM_AW-1:0] ROM_HI_BASE = ROM_HI_BASE_DEF
) (
   input  logic [ADDR_W-1:0] addr,
   input  logic              rnw,
   input  logic              cs_ram,
   input  logic              cs0,
   input  logic              cs1,
   input  logic [BANK_W-1:0] bank,
   input  logic [1:0]        ram_size,
   output logic [MEM_AW-1:0] map_addr_c,
   output logic              map_we_c
);

   logic [1:0] hi_bank;

   always_comb begin
      map_addr_c = '0;
      map_we_c   = 1'b0;
      hi_bank    = bank[3:2];
      if (!cs_ram) begin
         map_addr_c = {2'b00, addr & ram_mask(ram_size)};
         map_we_c   = ~rnw;
      end else if (!cs0) begin
         map_addr_c = ROM_LO_BASE + {2'b00, bank[1:0], addr[13:0]};
      end else if (!cs1) begin
         // Kernal common page is always visible from bank 0
         if (addr[15:8] == KERNAL_PAGE)
            hi_bank = 2'b00;
         map_addr_c = ROM_HI_BASE + {2'b00, hi_bank, addr[13:0]};
      end
   end

endmodule

// File: rtl/c16_memctl.sv
// c16_memctl: turns C16 bus accesses into req/ack transactions, owns ROM bank latch and DIN.
// Optional REQ abort/timeout logic is built only when C16_MEMCTL_TIMEOUT_EN is defined.
module c16_memctl
   import c16_mem_pkg::*;
#(
   parameter logic [MEM_AW-1:0] ROM_LO_BASE = ROM_LO_BASE_DEF,
   parameter logic [MEM_AW-1:0] ROM_HI_BASE = ROM_HI_BASE_DEF,
   parameter int unsigned       TIMEOUT     = 255
) (
   input  logic              CLK28,
   input  logic              RESET,
   input  logic [ADDR_W-1:0] ADDR,
   input  logic [DATA_W-1:0] DOUT,
   input  logic              RnW,
   input  logic              CS_RAM,
   input  logic              CS0,
   input  logic              CS1,
   input  logic [1:0]        ram_size,
   output logic [DATA_W-1:0] DIN,
   output logic              WAIT,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   output logic              mem_req,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              timeout_err
);

   state_t            state, state_nx;
   acc_key_t          key, prev_key;
   logic              any_cs, bank_wr, start_c, tmo_hit;
   logic              load_cmd, req_done, abort;
   logic [BANK_W-1:0] bank;
   logic              is_rd;
   logic [MEM_AW-1:0] map_addr_c;
   logic              map_we_c;

   assign key     = {ADDR, RnW, CS_RAM, CS0, CS1};
   assign any_cs  = ~(CS_RAM & CS0 & CS1);
   assign bank_wr = ~RnW && (ADDR[15:4] == BANK_REG_PAGE);
   // Bank register writes are absorbed here and never reach memory
   assign start_c = any_cs && (key != prev_key) && (state == IDLE) && !bank_wr;

   c16_memmap #(
      .ROM_LO_BASE (ROM_LO_BASE),
      .ROM_HI_BASE (ROM_HI_BASE)
   ) u_map (
      .addr       (ADDR),
      .rnw        (RnW),
      .cs_ram     (CS_RAM),
      .cs0        (CS0),
      .cs1        (CS1),
      .bank       (bank),
      .ram_size   (ram_size),
      .map_addr_c (map_addr_c),
      .map_we_c   (map_we_c)
   );

   // Key history keeps tracking through reset so a held access never retriggers
   always_ff @(posedge CLK28) prev_key <= key;

   always_ff @(posedge CLK28) begin
      if (RESET) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start_c) state_nx = SETTLE;
         SETTLE:  state_nx = REQ;
         REQ:     if (mem_ack || tmo_hit) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      load_cmd = 1'b0;
      req_done = 1'b0;
      abort    = 1'b0;
      WAIT     = start_c | (state != IDLE);
      case (state)
         SETTLE: load_cmd = 1'b1;
         REQ: begin
            if (mem_ack)      req_done = 1'b1;
            else if (tmo_hit) abort    = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK28) begin
      if (RESET) begin
         bank      <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         is_rd     <= 1'b0;
         DIN       <= 8'hFF;
      end else begin
         if (bank_wr) bank <= ADDR[3:0];
         if (load_cmd) begin
            mem_addr  <= map_addr_c;
            mem_we    <= map_we_c;
            mem_wdata <= DOUT;
            is_rd     <= RnW;
            mem_req   <= 1'b1;
         end
         if (req_done || abort) mem_req <= 1'b0;
         if (req_done && is_rd)   DIN <= mem_rdata;
         else if (abort && is_rd) DIN <= 8'hFF;
         else if (!any_cs)        DIN <= 8'hFF;
      end
   end

`ifdef C16_MEMCTL_TIMEOUT_EN
   logic [7:0] tcnt;

   assign tmo_hit = (tcnt == 8'(TIMEOUT - 1));

   always_ff @(posedge CLK28) begin
      if (RESET) begin
         tcnt        <= '0;
         timeout_err <= 1'b0;
      end else begin
         tcnt <= (state == REQ) ? tcnt + 8'd1 : 8'd0;
         if (abort) timeout_err <= 1'b1;
      end
   end
`else
   logic [7:0] unused_timeout;
   assign unused_timeout = 8'(TIMEOUT);
   assign tmo_hit        = 1'b0;
   assign timeout_err    = 1'b0;
`endif

endmodule

// File: tb/tb_c16_memctl.sv
// Scoreboard bench for c16_memctl: stimulus queues expected request/WAIT/DIN events,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_c16_memctl;

   localparam logic [1:0] K_REQ  = 2'd0;
   localparam logic [1:0] K_WAIT = 2'd1;
   localparam logic [1:0] K_DIN  = 2'd2;

   typedef struct packed {
      logic [1:0]  kind;
      logic [31:0] val;
   } exp_t;

   logic        CLK28 = 1'b0;
   logic        RESET;
   logic [15:0] ADDR;
   logic [7:0]  DOUT;
   logic        RnW;
   logic        CS_RAM, CS0, CS1;
   logic [1:0]  ram_size;
   logic [7:0]  DIN;
   logic        WAIT;
   logic [17:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_we;
   logic        mem_req;
   logic        mem_ack = 1'b0;
   logic [7:0]  mem_rdata = 8'h00;
   logic        timeout_err;

   exp_t sbq[$];
   int   nchk = 0;
   int   npass = 0;
   int   nfail = 0;
   int   cyc = 0;
   int   lat = 1;
   int   inject_cyc = -1;
   int   mcnt = 0;
   logic [7:0] rd_val = 8'h00;

   c16_memctl #(.TIMEOUT(8)) dut (
      .CLK28       (CLK28),
      .RESET       (RESET),
      .ADDR        (ADDR),
      .DOUT        (DOUT),
      .RnW         (RnW),
      .CS_RAM      (CS_RAM),
      .CS0         (CS0),
      .CS1         (CS1),
      .ram_size    (ram_size),
      .DIN         (DIN),
      .WAIT        (WAIT),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_we      (mem_we),
      .mem_req     (mem_req),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata),
      .timeout_err (timeout_err)
   );

   always #18 CLK28 = ~CLK28;
   always @(posedge CLK28) cyc <= cyc + 1;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act === exp) npass++;
      else begin
         nfail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endfunction

   // Memory: acks in the lat-th cycle of mem_req (lat = 0 never acks), plus one-shot stale ack
   always @(posedge CLK28) begin
      #1;
      mem_ack = 1'b0;
      if (!mem_req) mcnt = 0;
      else begin
         mcnt++;
         if (lat != 0 && mcnt == lat) begin
            mem_ack   = 1'b1;
            mem_rdata = rd_val;
         end
      end
      if (cyc == inject_cyc) begin
         mem_ack   = 1'b1;
         mem_rdata = 8'h77;
      end
   end

   // Monitor
   logic pw = 1'b0, pr = 1'b0;
   int   wlen = 0;
   always @(negedge CLK28) begin
      exp_t e;
      if (RESET) begin
         wlen = 0;
         pw   = 1'b0;
         pr   = mem_req;
      end else begin
         if (mem_req && !pr) begin
            if (sbq.size() == 0 || sbq[0].kind != K_REQ)
               chk("unexpected_req", {5'd0, mem_addr, mem_we, mem_wdata}, 32'hFFFF_FFFF);
            else begin
               e = sbq.pop_front();
               chk("req{addr,we,wdata}", {5'd0, mem_addr, mem_we, mem_wdata}, e.val);
            end
         end
         if (WAIT) wlen++;
         if (!WAIT && pw) begin
            if (sbq.size() == 0 || sbq[0].kind != K_WAIT)
               chk("unexpected_wait", 32'(wlen), 32'hFFFF_FFFF);
            else begin
               e = sbq.pop_front();
               chk("wait_cycles", 32'(wlen), e.val);
            end
            wlen = 0;
            if (sbq.size() != 0 && sbq[0].kind == K_DIN) begin
               e = sbq.pop_front();
               chk("din", 32'(DIN), e.val);
            end
         end
         pw = WAIT;
         pr = mem_req;
      end
   end

   task automatic release_bus();
      @(posedge CLK28); #1;
      {CS_RAM, CS0, CS1} = 3'b111;
      RnW = 1'b1;
      repeat (2) @(posedge CLK28);
   endtask

   // cs = {CS_RAM, CS0, CS1}, active low
   task automatic access(input logic [15:0] a, input logic rnw, input logic [2:0] cs,
                         input logic [1:0] rs, input logic [7:0] d_early, input logic [7:0] d_late,
                         input int l, input logic [7:0] rd, input logic [17:0] ea, input logic ewe,
                         input int ewait, input bit chk_din, input logic [7:0] edin, input int hold);
      bit done = 1'b0;
      sbq.push_back('{kind: K_REQ, val: {5'd0, ea, ewe, d_late}});
      sbq.push_back('{kind: K_WAIT, val: 32'(ewait)});
      if (chk_din) sbq.push_back('{kind: K_DIN, val: {24'd0, edin}});
      @(posedge CLK28); #1;
      lat = l; rd_val = rd; ram_size = rs;
      ADDR = a; RnW = rnw; {CS_RAM, CS0, CS1} = cs; DOUT = d_early;
      @(posedge CLK28); #1;
      DOUT = d_late;
      for (int i = 0; i < 100; i++) begin
         @(negedge CLK28);
         if (!WAIT) begin done = 1'b1; break; end
      end
      if (!done) chk("access_timeout", 32'd0, 32'd1);
      repeat (hold) @(posedge CLK28);
      release_bus();
   endtask

   initial begin
      bit seen;
      RESET = 1'b1; ADDR = '0; DOUT = '0; RnW = 1'b1;
      {CS_RAM, CS0, CS1} = 3'b111; ram_size = 2'd2;
      repeat (3) @(posedge CLK28);
      @(negedge CLK28);
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_wait", 32'(WAIT), 32'd0);
      chk("rst_din", 32'(DIN), 32'h0FF);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_timeout_err", 32'(timeout_err), 32'd0);
      @(posedge CLK28); #1 RESET = 1'b0;
      repeat (2) @(posedge CLK28);

      // RAM read, 64K
      access(16'h1234, 1'b1, 3'b011, 2'd2, 8'h00, 8'h00, 1, 8'hA5, 18'h01234, 1'b0, 3, 1, 8'hA5, 1);
      // 16K mirror write; data changes between start and SETTLE
      access(16'hC010, 1'b0, 3'b011, 2'd0, 8'h00, 8'h3C, 1, 8'h00, 18'h00010, 1'b1, 3, 0, 8'h00, 1);
      // 32K mirror read
      access(16'hC123, 1'b1, 3'b011, 2'd1, 8'h00, 8'h00, 1, 8'h5A, 18'h04123, 1'b0, 3, 1, 8'h5A, 1);
      // CS_RAM wins over CS0
      access(16'h8001, 1'b1, 3'b001, 2'd2, 8'h00, 8'h00, 1, 8'h11, 18'h08001, 1'b0, 3, 1, 8'h11, 1);

      // Bank latch write with CS1 low: no transaction, no stall
      @(posedge CLK28); #1;
      ADDR = 16'hFDD6; RnW = 1'b0; DOUT = 8'hEE; {CS_RAM, CS0, CS1} = 3'b110;
      @(negedge CLK28);
      chk("bankwr_wait", 32'(WAIT), 32'd0);
      @(negedge CLK28);
      chk("bankwr_mem_req", 32'(mem_req), 32'd0);
      release_bus();

      access(16'h8001, 1'b1, 3'b101, 2'd2, 8'h00, 8'h00, 1, 8'hC3, 18'h18001, 1'b0, 3, 1, 8'hC3, 1);
      access(16'hC000, 1'b1, 3'b110, 2'd2, 8'h00, 8'h00, 1, 8'h3E, 18'h24000, 1'b0, 3, 1, 8'h3E, 1);
      access(16'hFC20, 1'b1, 3'b110, 2'd2, 8'h00, 8'h00, 1, 8'h99, 18'h23C20, 1'b0, 3, 1, 8'h99, 1);
      // ROM write: no write enable, still acked
      access(16'hA000, 1'b0, 3'b101, 2'd2, 8'h55, 8'h55, 1, 8'h00, 18'h1A000, 1'b0, 3, 0, 8'h00, 1);
      // Slow memory, then key held stable
      access(16'h0100, 1'b1, 3'b011, 2'd2, 8'h00, 8'h00, 20, 8'h6B, 18'h00100, 1'b0, 22, 1, 8'h6B, 6);

      // Reset in the middle of REQ, stale ack afterwards
      sbq.push_back('{kind: K_REQ, val: {5'd0, 18'h02000, 1'b0, 8'h00}});
      @(posedge CLK28); #1;
      lat = 1000; ADDR = 16'h2000; RnW = 1'b1; DOUT = 8'h00; {CS_RAM, CS0, CS1} = 3'b011;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK28);
         if (mem_req) begin seen = 1'b1; break; end
      end
      chk("midreq_req_seen", 32'(seen), 32'd1);
      @(posedge CLK28); #1 RESET = 1'b1;
      repeat (2) @(posedge CLK28);
      #1 RESET = 1'b0;
      inject_cyc = cyc + 2;
      @(negedge CLK28);
      chk("midrst_mem_req", 32'(mem_req), 32'd0);
      chk("midrst_wait", 32'(WAIT), 32'd0);
      chk("midrst_din", 32'(DIN), 32'h0FF);
      repeat (4) @(negedge CLK28);
      chk("stale_ack_mem_req", 32'(mem_req), 32'd0);
      chk("stale_ack_wait", 32'(WAIT), 32'd0);
      chk("stale_ack_din", 32'(DIN), 32'h0FF);
      release_bus();
      // Bank back to 0 after reset
      access(16'h8001, 1'b1, 3'b101, 2'd2, 8'h00, 8'h00, 1, 8'h42, 18'h10001, 1'b0, 3, 1, 8'h42, 1);

`ifdef C16_MEMCTL_TIMEOUT_EN
      chk("pre_timeout_err", 32'(timeout_err), 32'd0);
      access(16'h0300, 1'b1, 3'b011, 2'd2, 8'h00, 8'h00, 0, 8'h00, 18'h00300, 1'b0, 10, 1, 8'hFF, 1);
      chk("timeout_err_set", 32'(timeout_err), 32'd1);
      access(16'h0301, 1'b1, 3'b011, 2'd2, 8'h00, 8'h00, 1, 8'h24, 18'h00301, 1'b0, 3, 1, 8'h24, 1);
      chk("timeout_err_sticky", 32'(timeout_err), 32'd1);
      @(posedge CLK28); #1 RESET = 1'b1;
      @(posedge CLK28); #1 RESET = 1'b0;
      @(negedge CLK28);
      chk("timeout_err_cleared", 32'(timeout_err), 32'd0);
`else
      chk("timeout_err_tied", 32'(timeout_err), 32'd0);
`endif

      repeat (4) @(posedge CLK28);
      chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
